ctrl_unit_pipe: RTL
===================

Name: ctrl_unit_pipe

Overview:
- Next-generation main decoder for the pipelined RV32 core: decodes opcode/funct3/funct7 in ID and registers the full control bundle into the ID/EX boundary.
- Adds a valid/ready handshake with the hazard unit, flush handling, extended ALU decode (OR/XOR/SRL/SRA/SLTU/AUIPC) and a multi-cycle MUL/DIV sequencer that stalls ID while busy.
- Sits between the IF/ID register and the EX stage.

Parameters:
MUL_LAT, 3, cycles from md_start to MUL result writeback (>=1)
DIV_LAT, 33, cycles from md_start to DIV/REM result writeback (>=1)
CNT_W, 6, down-counter width; must hold max(MUL_LAT,DIV_LAT)-1

Ports:
clk  in  1  core clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  IF/ID holds a real instruction
id_opcode  in  7  instr[6:0]
id_funct3  in  3  instr[14:12]
id_funct7  in  7  instr[31:25]
hz_bubble  in  1  hazard unit: hold ID, insert bubble into EX
ex_flush  in  1  kill ID/EX contents and abort any MUL/DIV
id_ready  out  1  combinational; ID instruction accepted this cycle when id_valid&id_ready
ex_valid  out  1  ID/EX bundle holds a live operation
ex_PCsrc  out  2  00 pc+4, 01 branch, 10 jal, 11 jalr
ex_Branch, ex_jump, ex_jalr, ex_IF_flush  out  1 each  as per opcode
ex_ALU_srcB  out  2  00 rs2, 01 U-imm, 10 I-imm, 11 S-imm
ex_alu_op  out  4  ALU code
ex_MemRead, ex_MemWrite, ex_Regwrite  out  1 each
ex_Mem2Reg  out  2  00 ALU, 01 mem, 10 pc+4, 11 MUL/DIV result
ex_md_start  out  1  one-cycle start pulse to MUL/DIV unit
ex_md_op  out  3  funct3 of the MUL/DIV instruction
ex_illegal  out  1  undecodable opcode/funct combination
md_busy  out  1  sequencer in MD_BUSY

Behaviour:
- Reset (rst_n low, async): every registered output 0, state IDLE, counter 0. id_ready is 0 while rst_n is low.
- id_ready = rst_n & ~hz_bubble & ~ex_flush & (state==IDLE).
- Accept (id_valid&id_ready) at edge N: ex_* carry the decoded bundle at N+1, ex_valid=1. No accept: ex_valid=0 and every ex_* output cleared to 0 (bubble); ID must be held upstream.
- Decode table:
  - R: srcB 00, Regwrite 1, Mem2Reg 00.
  - I-ALU: srcB 10, Regwrite 1.
  - LW: srcB 10, MemRead 1, Mem2Reg 01, Regwrite 1, alu 0010.
  - SW: srcB 11, MemWrite 1, alu 0010.
  - B: PCsrc 01, Branch 1.
  - JAL: PCsrc 10, jump 1, IF_flush 1, Mem2Reg 10, Regwrite 1.
  - JALR: JAL values plus PCsrc 11, srcB 10, jalr 1.
  - LUI: srcB 01, Regwrite 1, alu 0010.
  - AUIPC (0010111): srcB 01, Regwrite 1, alu 1101 (pc+imm).
- ALU codes:
  - ADD 0010, SUB 0110, SLL 0100, SLT 0111, SLTU 1011, AND 0000, OR 0001, XOR 1100, SRL 1000, SRA 1001.
  - I-type uses funct3; SRAI when funct7=0100000.
- Branch ALU codes: BEQ/BNE 0110, BLT 0111, BGE 1111, BLTU 1011, BGEU 0011.
- Illegal: any other opcode or R-type funct7/funct3 pair. Result: ex_illegal=1, ex_valid=1, all write/mem/branch strobes 0.
- FSM IDLE / MD_BUSY:
  - Accepting an M-type instruction (opcode 0110011, funct7 0000001) gives, next cycle: ex_md_start=1, ex_md_op=funct3, ex_Regwrite=0, state MD_BUSY.
  - Counter loads MUL_LAT-1 for funct3[2]=0, otherwise DIV_LAT-1.
- MD_BUSY:
  - Counter decrements each cycle; ex_valid=0 (bubble) while counter>0.
  - Counter==0: next cycle ex_valid=1, Regwrite=1, Mem2Reg=11, state IDLE; id_ready may rise in that same cycle.
- ex_flush (highest priority): next edge ex_valid=0, all strobes 0, state IDLE, counter 0. A flush coinciding with counter==0 suppresses the writeback.
- hz_bubble during MD_BUSY: no effect on the counter.

Optional Feature:
RV32M_EN
- Defined: M-type decode and the MD_BUSY sequencer exist as described.
- Undefined: funct7 0000001 decodes as illegal (ex_illegal=1), md_busy and ex_md_start tied 0, and the FSM and counter are not synthesised.

Test Plan:
- Reset: rst_n=0 mid-stream -> all outputs 0 and id_ready=0 immediately; after release with id_valid=1, ADD (funct3 000, funct7 0) -> next cycle ex_valid=1, alu 0010, Regwrite 1.
- Back-to-back SW then LW then BGEU -> consecutive cycles carry MemWrite 1/srcB 11; MemRead 1/Mem2Reg 01; Branch 1/alu 0011.
- hz_bubble=1 with LW present -> id_ready=0; next cycle ex_valid=0 and all strobes 0; LW issues the cycle after hz_bubble drops.
- MUL with MUL_LAT=3 -> md_start at T+1, ex_valid=0 at T+2..T+3, writeback Regwrite 1/Mem2Reg 11 at T+4; id_ready=0 from T+1 to T+3.
- DIV then ex_flush asserted at counter==5 -> next cycle md_busy=0 and no writeback; following ADD accepted.
- Opcode 0000000 -> ex_illegal=1 and Regwrite/MemWrite 0; with RV32M_EN undefined, MUL -> ex_illegal=1 and md_start never asserts.

Source files
------------

// File: rtl/ctrl_unit_pipe.sv
// ctrl_unit_pipe: ID-stage main decoder, registers the control bundle into ID/EX.
// Define RV32M_EN to build M-extension decode and the MUL/DIV sequencer.
module ctrl_unit_pipe #(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [6:0] id_opcode,
    input  logic [2:0] id_funct3,
    input  logic [6:0] id_funct7,
    input  logic       hz_bubble,
    input  logic       ex_flush,
    output logic       id_ready,
    output logic       ex_valid,
    output logic [1:0] ex_PCsrc,
    output logic       ex_Branch,
    output logic       ex_jump,
    output logic       ex_jalr,
    output logic       ex_IF_flush,
    output logic [1:0] ex_ALU_srcB,
    output logic [3:0] ex_alu_op,
    output logic       ex_MemRead,
    output logic       ex_MemWrite,
    output logic       ex_Regwrite,
    output logic [1:0] ex_Mem2Reg,
    output logic       ex_md_start,
    output logic [2:0] ex_md_op,
    output logic       ex_illegal,
    output logic       md_busy
);

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ALT   = 7'b0100000;

    typedef struct packed {
        logic       valid;
        logic [1:0] pcsrc;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       if_flush;
        logic [1:0] srcb;
        logic [3:0] alu;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_wr;
        logic [1:0] m2r;
        logic       md_start;
        logic [2:0] md_op;
        logic       illegal;
    } ctrl_t;

    ctrl_t      dec;
    ctrl_t      ex_q;
    logic [3:0] alu_f3;
    logic       illegal;
    logic       accept;

    always_comb begin
        alu_f3 = 4'b0010;
        unique case (id_funct3)
            3'b000: alu_f3 = 4'b0010;
            3'b001: alu_f3 = 4'b0100;
            3'b010: alu_f3 = 4'b0111;
            3'b011: alu_f3 = 4'b1011;
            3'b100: alu_f3 = 4'b1100;
            3'b101: alu_f3 = (id_funct7 == F7_ALT) ? 4'b1001 : 4'b1000;
            3'b110: alu_f3 = 4'b0001;
            3'b111: alu_f3 = 4'b0000;
        endcase
    end

    always_comb begin
        dec       = '0;
        dec.valid = 1'b1;
        illegal   = 1'b0;
        unique case (id_opcode)
            OP_R: begin
                dec.reg_wr = 1'b1;
                dec.alu    = alu_f3;
                if (id_funct7 == F7_ALT) begin
                    if (id_funct3 == 3'b000)
                        dec.alu = 4'b0110;
                    else if (id_funct3 != 3'b101)
                        illegal = 1'b1;
                end
`ifdef RV32M_EN
                else if (id_funct7 == 7'b0000001) begin
                    dec.reg_wr   = 1'b0;
                    dec.alu      = 4'b0000;
                    dec.md_start = 1'b1;
                    dec.md_op    = id_funct3;
                end
`endif
                else if (id_funct7 != 7'b0000000) begin
                    illegal = 1'b1;
                end
            end
            OP_I: begin
                dec.srcb   = 2'b10;
                dec.reg_wr = 1'b1;
                dec.alu    = alu_f3;
            end
            OP_LW: begin
                dec.srcb   = 2'b10;
                dec.mem_rd = 1'b1;
                dec.m2r    = 2'b01;
                dec.reg_wr = 1'b1;
                dec.alu    = 4'b0010;
            end
            OP_SW: begin
                dec.srcb   = 2'b11;
                dec.mem_wr = 1'b1;
                dec.alu    = 4'b0010;
            end
            OP_B: begin
                dec.pcsrc  = 2'b01;
                dec.branch = 1'b1;
                case (id_funct3)
                    3'b100:  dec.alu = 4'b0111;
                    3'b101:  dec.alu = 4'b1111;
                    3'b110:  dec.alu = 4'b1011;
                    3'b111:  dec.alu = 4'b0011;
                    default: dec.alu = 4'b0110;
                endcase
            end
            OP_JAL, OP_JALR: begin
                dec.pcsrc    = 2'b10;
                dec.jump     = 1'b1;
                dec.if_flush = 1'b1;
                dec.m2r      = 2'b10;
                dec.reg_wr   = 1'b1;
                if (id_opcode == OP_JALR) begin
                    dec.pcsrc = 2'b11;
                    dec.srcb  = 2'b10;
                    dec.jalr  = 1'b1;
                end
            end
            OP_LUI: begin
                dec.srcb   = 2'b01;
                dec.reg_wr = 1'b1;
                dec.alu    = 4'b0010;
            end
            OP_AUIPC: begin
                dec.srcb   = 2'b01;
                dec.reg_wr = 1'b1;
                dec.alu    = 4'b1101;
            end
            default: illegal = 1'b1;
        endcase
        // Illegal ops still occupy EX so the trap is raised, but no side effects.
        if (illegal) begin
            dec         = '0;
            dec.valid   = 1'b1;
            dec.illegal = 1'b1;
        end
    end

`ifdef RV32M_EN
    typedef enum logic {IDLE, MD_BUSY} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       md_op_q;
    ctrl_t            wb;

    assign id_ready = rst_n & ~hz_bubble & ~ex_flush & (state == IDLE);
    assign md_busy  = (state == MD_BUSY);
    assign accept   = id_valid & id_ready;

    always_comb begin
        wb        = '0;
        wb.valid  = 1'b1;
        wb.reg_wr = 1'b1;
        wb.m2r    = 2'b11;
        wb.md_op  = md_op_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            state   <= IDLE;
            cnt     <= '0;
            md_op_q <= '0;
        end else if (ex_flush) begin
            ex_q  <= '0;
            state <= IDLE;
            cnt   <= '0;
        end else if (state == MD_BUSY) begin
            if (cnt == '0) begin
                ex_q  <= wb;
                state <= IDLE;
            end else begin
                ex_q <= '0;
                cnt  <= cnt - 1'b1;
            end
        end else if (accept) begin
            ex_q <= dec;
            if (dec.md_start) begin
                state   <= MD_BUSY;
                md_op_q <= id_funct3;
                cnt     <= id_funct3[2] ? CNT_W'(DIV_LAT - 1)
                                        : CNT_W'(MUL_LAT - 1);
            end
        end else begin
            ex_q <= '0;
        end
    end
`else
    localparam logic [CNT_W-1:0] LAT_SUM = CNT_W'(MUL_LAT + DIV_LAT);

    logic unused_lat;

    assign unused_lat = ^LAT_SUM;
    assign id_ready   = rst_n & ~hz_bubble & ~ex_flush;
    assign md_busy    = 1'b0;
    assign accept     = id_valid & id_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_q <= '0;
        else if (ex_flush || !accept)
            ex_q <= '0;
        else
            ex_q <= dec;
    end
`endif

    assign ex_valid    = ex_q.valid;
    assign ex_PCsrc    = ex_q.pcsrc;
    assign ex_Branch   = ex_q.branch;
    assign ex_jump     = ex_q.jump;
    assign ex_jalr     = ex_q.jalr;
    assign ex_IF_flush = ex_q.if_flush;
    assign ex_ALU_srcB = ex_q.srcb;
    assign ex_alu_op   = ex_q.alu;
    assign ex_MemRead  = ex_q.mem_rd;
    assign ex_MemWrite = ex_q.mem_wr;
    assign ex_Regwrite = ex_q.reg_wr;
    assign ex_Mem2Reg  = ex_q.m2r;
    assign ex_md_start = ex_q.md_start;
    assign ex_md_op    = ex_q.md_op;
    assign ex_illegal  = ex_q.illegal;

endmodule
